// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: start bit, WIDTH data bits LSB first, optional even
// parity, stop bit. The line idles high and sdo comes straight from a flop.
module serial_frame_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    output logic             sdo,
    output logic             busy,
    output logic             done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cyc_q, cyc_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [WIDTH-1:0]  sh_q, sh_d;
    logic              par_q, par_d;
    logic              sdo_q, sdo_d;
    logic              done_q, done_d;
    logic              bit_end;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            sdo_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            sdo_q   <= sdo_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        par_d   = par_q;
        done_d  = 1'b0;
        bit_end = (cyc_q == CYC_LAST);

        if (state_q != IDLE)
            cyc_d = bit_end ? '0 : cyc_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = START;
                    sh_d    = din;
                    par_d   = ^din;
                    cyc_d   = '0;
                    bit_d   = '0;
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == BIT_LAST) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        sh_d  = sh_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is decoded from the upcoming state so sdo lines up with it.
        case (state_d)
            START:   sdo_d = 1'b0;
            DATA:    sdo_d = sh_d[0];
            PARITY:  sdo_d = par_d;
            default: sdo_d = 1'b1;
        endcase
    end

    always_comb begin
        in_ready = (state_q == IDLE);
        busy     = (state_q != IDLE);
        sdo      = sdo_q;
        done     = done_q;
    end

endmodule
